// File: rtl/gray2binary_pipe.sv
// Pipelined Gray-to-binary decoder with a single-bit-step checker on accepted words.
// Latency: N = WIDTH/STAGE_BITS cycles; registered outputs; throughput 1 word/cycle.
// Backpressure: the whole pipe advances only when the output slot is empty or taken (in_ready = adv).
module gray2binary_pipe #(
    parameter int WIDTH      = 12,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             step_err,
    output logic [7:0]       err_count
);

    localparam int N = WIDTH / STAGE_BITS;

    logic             adv;
    logic             accept;
    logic             step_tag;
    logic [WIDTH-1:0] gray_diff;

    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             have_prev_q, have_prev_d;
    logic [7:0]       err_count_q, err_count_d;

    logic [WIDTH-1:0] stg_gray [N];
    logic [WIDTH-1:0] stg_bin  [N];
    logic             stg_vld  [N];
    logic             stg_err  [N];

    assign out_valid = stg_vld[N-1];
    assign out_bin   = stg_bin[N-1];
    assign step_err  = stg_err[N-1];
    assign err_count = err_count_q;

    // Bubbles are not collapsed: every stage moves together on adv.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign gray_diff = in_gray ^ prev_gray_q;
    assign step_tag  = have_prev_q & (|(gray_diff & (gray_diff - WIDTH'(1))));

    always_comb begin
        prev_gray_d = prev_gray_q;
        have_prev_d = have_prev_q;
        err_count_d = err_count_q;
        if (accept) begin
            prev_gray_d = in_gray;
            have_prev_d = 1'b1;
        end
        if (out_valid && out_ready && step_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_q <= '0;
            have_prev_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            prev_gray_q <= prev_gray_d;
            have_prev_q <= have_prev_d;
            err_count_q <= err_count_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int HI = WIDTH - 1 - k * STAGE_BITS;

        logic [WIDTH-1:0]      src_gray;
        logic [WIDTH-1:0]      src_bin;
        logic                  src_vld;
        logic                  src_err;
        logic                  seed;
        logic [STAGE_BITS:0]   chain;
        logic [STAGE_BITS-1:0] res_bits;
        logic [WIDTH-1:0]      res_bin;

        logic [WIDTH-1:0]      gray_q, gray_d;
        logic [WIDTH-1:0]      bin_q, bin_d;
        logic                  vld_q, vld_d;
        logic                  err_q, err_d;

        if (k == 0) begin : g_head
            assign src_gray = in_gray;
            assign src_bin  = '0;
            assign src_vld  = in_valid;
            assign src_err  = step_tag;
            assign seed     = 1'b0;
        end else begin : g_body
            assign src_gray = stg_gray[k-1];
            assign src_bin  = stg_bin[k-1];
            assign src_vld  = stg_vld[k-1];
            assign src_err  = stg_err[k-1];
            // Lowest binary bit resolved by the previous stage seeds the XOR chain.
            assign seed     = stg_bin[k-1][WIDTH - k * STAGE_BITS];
        end

        assign chain[0] = seed;
        for (genvar j = 0; j < STAGE_BITS; j++) begin : g_bit
            assign chain[j+1]                 = chain[j] ^ src_gray[HI - j];
            assign res_bits[STAGE_BITS-1-j]   = chain[j+1];
        end

        always_comb begin
            res_bin                      = src_bin;
            res_bin[HI -: STAGE_BITS]    = res_bits;
        end

        always_comb begin
            gray_d = gray_q;
            bin_d  = bin_q;
            vld_d  = vld_q;
            err_d  = err_q;
            if (adv) begin
                gray_d = src_gray;
                bin_d  = res_bin;
                vld_d  = src_vld;
                err_d  = src_err;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                gray_q <= '0;
                bin_q  <= '0;
                vld_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                gray_q <= gray_d;
                bin_q  <= bin_d;
                vld_q  <= vld_d;
                err_q  <= err_d;
            end
        end

        assign stg_gray[k] = gray_q;
        assign stg_bin[k]  = bin_q;
        assign stg_vld[k]  = vld_q;
        assign stg_err[k]  = err_q;
    end

endmodule

// File: tb/tb_gray2binary_pipe.sv
// Directed bench for gray2binary_pipe: vector table plus hand-written latency, stall, reset and saturation sequences.
module tb_gray2binary_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_gray;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bin;
    logic        step_err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    logic [12:0] q [$];

    typedef struct {
        logic [11:0] gray;
        logic [11:0] bin;
        logic        err;
    } vec_t;

    gray2binary_pipe #(.WIDTH(12), .STAGE_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .step_err  (step_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) q.push_back({step_err, out_bin});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_gray(input int b);
        logic [11:0] v;
        v = b[11:0];
        return v ^ (v >> 1);
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_gray   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // mode 0: Gray of idx (mod 4096); mode 1: alternating 0x000/0x0FF.
    task automatic stream(input string name, input int n, input int mode,
                          input int st, input int sl);
        int          idx = 0;
        int          c = 0;
        int          bad = 0;
        int          first_bad = -1;
        logic        acc;
        logic        stalled = 1'b0;
        logic [11:0] held = '0;
        q.delete();
        while (q.size() < n && c < n + 100) begin
            out_ready = !(c >= st && c < st + sl);
            in_valid  = (idx < n);
            in_gray   = (mode == 0) ? to_gray(idx % 4096) : (idx[0] ? 12'h0FF : 12'h000);
            @(negedge clk);
            acc = in_valid & in_ready;
            if (out_valid && !out_ready) begin
                if (stalled) begin
                    chk({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
                    chk({name, "_stall_hold"}, 32'(out_bin), 32'(held));
                end
                held    = out_bin;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_count"}, 32'(q.size()), 32'(n));
        if (mode == 0) begin
            foreach (q[i]) begin
                if (q[i] !== {1'b0, 12'(i % 4096)}) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            if (bad != 0) $display("first bad index %0d", first_bad);
            chk({name, "_order_mismatches"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs [13];
        int   found;

        vecs[0]  = '{12'h000, 12'h000, 1'b0};
        vecs[1]  = '{12'h000, 12'h000, 1'b0};
        vecs[2]  = '{12'h001, 12'h001, 1'b0};
        vecs[3]  = '{12'h003, 12'h002, 1'b0};
        vecs[4]  = '{12'h002, 12'h003, 1'b0};
        vecs[5]  = '{12'hC00, 12'h800, 1'b1};
        vecs[6]  = '{12'h800, 12'hFFF, 1'b0};
        vecs[7]  = '{12'h000, 12'h000, 1'b0};
        vecs[8]  = '{12'h003, 12'h002, 1'b1};
        vecs[9]  = '{12'h002, 12'h003, 1'b0};
        vecs[10] = '{12'hFFF, 12'hAAA, 1'b1};
        vecs[11] = '{12'hA5A, 12'hC6C, 1'b1};
        vecs[12] = '{12'h123, 12'h1C2, 1'b1};

        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bin",   32'(out_bin),   32'd0);
        chk("rst_step_err",  32'(step_err),  32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Vector table, back to back with the consumer always ready.
        @(posedge clk);
        #1;
        q.delete();
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_gray  = vecs[i].gray;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("tab_count", 32'(q.size()), 32'd13);
        for (int i = 0; i < 13; i++) begin
            if (i < q.size()) begin
                chk($sformatf("tab_bin_%0d", i), 32'(q[i][11:0]), 32'(vecs[i].bin));
                chk($sformatf("tab_err_%0d", i), 32'(q[i][12]), 32'(vecs[i].err));
            end
        end
        chk("tab_err_count", 32'(err_count), 32'd5);

        // Latency: accepted at edge t, visible after edge t+2.
        do_reset();
        in_valid = 1'b1;
        in_gray  = 12'hC00;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_t0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("lat_t2_bin",   32'(out_bin),   32'h800);
        chk("lat_t2_err",   32'(step_err),  32'd0);

        // Step error and the edge at which err_count moves.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_gray  = (i == 0) ? 12'h000 : ((i == 1) ? 12'h003 : 12'h002);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (out_valid && step_err) found = 1;
        end
        chk("serr_seen", 32'(found), 32'd1);
        chk("serr_bin", 32'(out_bin), 32'h002);
        chk("serr_cnt_before", 32'(err_count), 32'd0);
        @(negedge clk);
        chk("serr_cnt_after", 32'(err_count), 32'd1);
        chk("serr_next_bin", 32'(out_bin), 32'h003);
        chk("serr_next_err", 32'(step_err), 32'd0);

        do_reset();
        stream("sweep", 4097, 0, 1 << 30, 0);
        chk("sweep_err_count", 32'(err_count), 32'd0);

        do_reset();
        stream("bp", 21, 0, 8, 5);
        chk("bp_err_count", 32'(err_count), 32'd0);

        do_reset();
        stream("sat", 300, 1, 1 << 30, 0);
        chk("sat_err_count", 32'(err_count), 32'd255);

        // Reset with three words in flight and the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_gray  = to_gray(i + 5);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt",   32'(err_count), 32'd0);
        chk("mid_rst_bin",   32'(out_bin),   32'd0);
        q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_gray  = 12'hFFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_post_count", 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
            chk("mid_post_bin", 32'(q[0][11:0]), 32'hAAA);
            chk("mid_post_err", 32'(q[0][12]),   32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray2binary_pipe.md
# gray2binary_pipe

Pipelined Gray-to-binary decoder with valid/ready handshakes on both sides, the receive-side counterpart of the pattern generator's binary-to-Gray encoder. It accepts one WIDTH-bit Gray word per cycle and resolves STAGE_BITS binary bits per pipeline stage, MSB first. It also checks the Gray single-bit-step property between consecutive accepted words and flags violations. It sits between the Gray-coded pattern/pointer source and the binary consumers (comparators, address logic).

## Interface
- WIDTH, 12: data width in bits; must be an integer multiple of STAGE_BITS.
- STAGE_BITS, 4: binary bits resolved per stage. Number of stages N = WIDTH/STAGE_BITS (default 3).
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  Gray word on in_gray is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_gray  input  WIDTH  Gray-coded input word.
- out_valid  output  1  out_bin is valid.
- out_ready  input  1  consumer accepts out_bin this cycle.
- out_bin  output  WIDTH  decoded binary word.
- step_err  output  1  qualified by out_valid; the word is more than one bit away from the previously accepted word.
- err_count  output  8  saturating count of delivered words with step_err=1.

## Operation
- Decode rule: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i < WIDTH-1.
- Stage k (k = 0..N-1) registers the Gray word, the binary bits resolved so far, the step_err tag and a valid bit. It computes the next STAGE_BITS binary bits from the MSB down, using the lowest binary bit resolved by the previous stage as the chain seed.
- Advance enable: adv = !out_valid | out_ready. When adv=1, every stage shifts one position and stage valid bits shift with it. When adv=0, all stages hold.
- in_ready = adv. An input is accepted when in_valid & in_ready.
- Bubbles are not collapsed. An invalid slot travels through the pipe like data.
- Step check at acceptance:
  - d = in_gray ^ prev_gray; step_err tag = have_prev & (popcount(d) > 1).
  - On each accept, prev_gray <= in_gray and have_prev <= 1.
  - popcount 0 (repeated word) and popcount 1 are both legal.
  - The first word after reset is never flagged.
- Wrap-around: Gray 0x800 to 0x000 (binary 4095 to 0, at WIDTH=12) differs in one bit and is legal.
- err_count increments by 1 on each output handshake (out_valid & out_ready) with step_err=1. It saturates at 255 and never wraps.
- Reset values: all stage valid bits = 0, out_valid = 0, out_bin = 0, step_err = 0, err_count = 0, prev_gray = 0, have_prev = 0. in_ready = 1 during the cycle after reset.
- Reset mid-operation: all in-flight words are discarded, with no partial output. The next accepted word is treated as the first.
- Simultaneous accept and deliver in the same cycle is the normal streaming case. Throughput is 1 word per cycle whenever out_ready=1.

## Timing
- Latency: a word accepted at rising edge t appears with out_valid=1 after edge t+N-1. That is N cycles in the pipe (3 at default).
- out_bin, out_valid and step_err are registered outputs with no combinational path from inputs.
- in_ready depends combinationally on out_ready; there is no combinational path from in_valid.
- Stall: while out_valid=1 and out_ready=0, out_bin/step_err are held stable, in_ready=0 and no stage changes.
- err_count updates at the edge that completes the erroring output handshake.

## Test plan
- Single words with out_ready=1: gray 0x000 -> bin 0x000; 0xC00 -> 0x800; 0x800 -> 0xFFF. Each arrives 3 cycles after acceptance with step_err=0 after the first.
- Full sweep: Gray of 0..4095 then 0, back-to-back, out_ready=1 -> bin 0..4095, 0 in order at 1 word/cycle; step_err never set; err_count=0.
- Step error: accept 0x000 then 0x003 -> second output bin=0x002 with step_err=1, err_count=1 after its handshake; following word 0x002 -> bin 0x003, step_err=0.
- Backpressure: stream Gray of 0..20, drop out_ready for 5 cycles mid-stream -> in_ready=0 and out_bin held during the stall; no loss or duplication; order preserved.
- Reset mid-stream: assert rst with 3 words in flight -> out_valid=0 next cycle, err_count=0; first post-reset word 0xFFF is not flagged.
- Saturation: 300 alternating 0x000/0x0FF words -> err_count stops at 255.
